// File: rtl/comparator_iter.sv
// Iterative magnitude comparator: walks the operands one digit per clock
// from the top and stops at the first differing digit.
module comparator_iter #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Gt,
  output logic             Sm
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IW-1:0]    TOP_IDX = IW'(NDIG - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;

  // Operands are shifted left each step, so the live digit is always on top
  // and no WIDTH-wide index mux sits on the compare path.
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Eq    <= 1'b0;
      Gt    <= 1'b0;
      Sm    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // Flipping both sign bits maps signed order onto unsigned order.
            a_q   <= signed_mode ? (A ^ MSB_BIT) : A;
            b_q   <= signed_mode ? (B ^ MSB_BIT) : B;
            idx   <= TOP_IDX;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (a_dig != b_dig) begin
            Eq    <= 1'b0;
            Gt    <= a_dig > b_dig;
            Sm    <= a_dig < b_dig;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            Eq    <= 1'b1;
            Gt    <= 1'b0;
            Sm    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - IW'(1);
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_iter.sv
// Bench for comparator_iter: directed plan cases plus random compares
// against an arithmetic reference model.
module tb_comparator_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        smode;
  logic [15:0] a16, b16;
  logic        busy16, done16, eq16, gt16, sm16;
  logic [7:0]  a8, b8;
  logic        start8;
  logic        busy8, done8, eq8, gt8, sm8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comparator_iter #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(smode),
    .A(a16), .B(b16), .busy(busy16), .done(done16),
    .Eq(eq16), .Gt(gt16), .Sm(sm16)
  );

  comparator_iter #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(smode),
    .A(a8), .B(b8), .busy(busy8), .done(done8),
    .Eq(eq8), .Gt(gt8), .Sm(sm8)
  );

  // Reference: result code {eq,gt,sm} from plain arithmetic.
  function automatic logic [2:0] ref_res16(logic [15:0] a, logic [15:0] b,
                                           logic s);
    if (a == b) return 3'b100;
    if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
    return (a > b) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [2:0] ref_res8(logic [7:0] a, logic [7:0] b,
                                          logic s);
    if (a == b) return 3'b100;
    if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
    return (a > b) ? 3'b010 : 3'b001;
  endfunction

  // Latency = digits examined up to and including the first differing one.
  function automatic int ref_lat16(logic [15:0] a, logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      if (((a >> (12 - 4 * i)) & 16'hF) != ((b >> (12 - 4 * i)) & 16'hF))
        return i + 1;
    end
    return 4;
  endfunction

  // Entered #1 after an edge; returns #1 after the done edge (done cycle).
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input bit poke,
                       output int lat, output logic [2:0] res,
                       output logic b0, output logic bdone);
    start = 1'b1; a16 = a; b16 = b; smode = s;
    @(posedge clk); #1;
    start = 1'b0;
    b0 = busy16;
    lat = -1; res = 3'bxxx; bdone = 1'bx;
    if (poke) begin
      a16 = 16'h0000; b16 = 16'hFFFF; smode = ~s;
    end
    for (int c = 1; c <= 8; c++) begin
      if (poke && c == 2) start = 1'b1;
      @(posedge clk); #1;
      if (done16) begin
        lat = c; res = {eq16, gt16, sm16}; bdone = busy16;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; smode = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, eq16, gt16, sm16} !== 5'b0) begin
      bad++;
      $display("FAIL reset16 got=%b want=00000",
               {busy16, done16, eq16, gt16, sm16});
    end
    total++;
    if ({busy8, done8, eq8, gt8, sm8} !== 5'b0) begin
      bad++;
      $display("FAIL reset8 got=%b want=00000", {busy8, done8, eq8, gt8, sm8});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int lat; logic [2:0] res; logic b0, bd;
    // equal operands: full walk
    run16(16'h1234, 16'h1234, 1'b0, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 4 || res !== 3'b100 || b0 !== 1'b1 || bd !== 1'b0) begin
      bad++;
      $display("FAIL eq1234 lat=%0d res=%b busy0=%b busyd=%b want 4 100 1 0",
               lat, res, b0, bd);
    end
    run16(16'h8000, 16'h7FFF, 1'b0, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 1 || res !== 3'b010) begin
      bad++;
      $display("FAIL u8000 lat=%0d res=%b want 1 010", lat, res);
    end
    run16(16'h8000, 16'h7FFF, 1'b1, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 1 || res !== 3'b001) begin
      bad++;
      $display("FAIL s8000 lat=%0d res=%b want 1 001", lat, res);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [2:0] res; logic b0, bd;
    run16(16'h12A4, 16'h1294, 1'b0, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 3 || res !== 3'b010) begin
      bad++;
      $display("FAIL b2b_first lat=%0d res=%b want 3 010", lat, res);
    end
    // next start raised inside the done cycle
    run16(16'h0001, 16'h0002, 1'b0, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 4 || res !== 3'b001 || b0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second lat=%0d res=%b busy0=%b want 4 001 1",
               lat, res, b0);
    end
  endtask

  task automatic test_ignore_start;
    int lat; logic [2:0] res; logic b0, bd;
    run16(16'hFFFF, 16'hFFFE, 1'b1, 1'b1, lat, res, b0, bd);
    total++;
    if (lat !== 4 || res !== 3'b010) begin
      bad++;
      $display("FAIL ignore lat=%0d res=%b want 4 010", lat, res);
    end
    @(posedge clk); #1;
    total++;
    if (busy16 !== 1'b0 || {eq16, gt16, sm16} !== 3'b010) begin
      bad++;
      $display("FAIL ignore_after busy=%b res=%b want 0 010",
               busy16, {eq16, gt16, sm16});
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [2:0] res; logic b0, bd; int pulses;
    // flush the previous result so the abort check sees cleared flags
    start = 1'b1; a16 = 16'h1234; b16 = 16'h1234; smode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy16, done16, eq16, gt16, sm16} !== 5'b0) begin
      bad++;
      $display("FAIL abort got=%b want=00000",
               {busy16, done16, eq16, gt16, sm16});
    end
    pulses = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done16 || busy16) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL abort_quiet got=%0d want=0", pulses);
    end
    run16(16'h0F00, 16'h0E00, 1'b0, 1'b0, lat, res, b0, bd);
    total++;
    if (lat !== 2 || res !== 3'b010) begin
      bad++;
      $display("FAIL post_reset lat=%0d res=%b want 2 010", lat, res);
    end
  endtask

  task automatic test_single_digit;
    logic [7:0] av [2] = '{8'h7F, 8'h80};
    logic [7:0] bv [2] = '{8'h80, 8'h80};
    for (int i = 0; i < 2; i++) begin
      int lat;
      logic [2:0] res;
      start8 = 1'b1; a8 = av[i]; b8 = bv[i]; smode = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = -1; res = 3'bxxx;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        if (done8) begin
          lat = c; res = {eq8, gt8, sm8};
          break;
        end
      end
      total++;
      if (lat !== 1 || res !== ref_res8(av[i], bv[i], 1'b1)) begin
        bad++;
        $display("FAIL w8_%0d lat=%0d res=%b want 1 %b",
                 i, lat, res, ref_res8(av[i], bv[i], 1'b1));
      end
    end
  endtask

  task automatic test_random;
    int lat; logic [2:0] res; logic b0, bd;
    int errs = 0;
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a, b, flip;
      logic s;
      a = 16'($urandom);
      s = 1'($urandom);
      // force a shared prefix of random length to exercise every latency
      flip = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      b = (n % 7 == 0) ? a : (a ^ flip);
      run16(a, b, s, 1'b0, lat, res, b0, bd);
      total++;
      if (lat !== ref_lat16(a, b) || res !== ref_res16(a, b, s) ||
          bd !== 1'b0) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL rand a=%h b=%h s=%b lat=%0d res=%b want %0d %b",
                   a, b, s, lat, res, ref_lat16(a, b), ref_res16(a, b, s));
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_reset_abort;
    test_single_digit;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_iter.md
# comparator_iter

Parametrised iterative magnitude comparator and the next generation of the team's 4-bit combinational comparator. It compares two WIDTH-bit operands, unsigned or two's-complement, DIGIT bits per clock from the most significant digit down. It stops at the first differing digit and reports Eq/Gt/Sm through a start/busy/done handshake. It is used where wide compares must not form one long combinational path.

## Interface
- WIDTH, 16: operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4: bits examined per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT digits.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request a compare; sampled only while idle.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
- A  in  WIDTH  first operand; captured on an accepted start.
- B  in  WIDTH  second operand; captured on an accepted start.
- busy  out  1  compare in progress.
- done  out  1  one-cycle pulse: the result is updated this cycle.
- Eq  out  1  A == B
- Gt  out  1  A > B
- Sm  out  1  A < B

## Operation
- The block has two states, IDLE and RUN. A digit index idx ranges from NDIG-1 (most significant) to 0.
- Reset (rst_n=0 at an edge) sets the state to IDLE and sets busy, done, Eq, Gt and Sm all to 0.
  - Reset wins over every other input.
  - Reset mid-compare aborts the compare: no done pulse, and the captured operands are discarded.
- IDLE with start=1: capture A, B and signed_mode, set idx=NDIG-1, go to RUN, busy=1.
  - In signed mode, invert the MSB of both captured operands at capture. After that, the unsigned digit compare gives the signed result.
- RUN, each cycle: compare digit idx of the two captured operands as unsigned DIGIT-bit values.
  - Digits differ: set Gt=1 if the A digit is larger, otherwise Sm=1. Set Eq=0, pulse done, go to IDLE.
  - Digits equal and idx=0: set Eq=1, Gt=0, Sm=0. Pulse done, go to IDLE.
  - Digits equal and idx>0: decrement idx and stay in RUN.
- Eq/Gt/Sm are registered and hold their value until the next done. After the first done, exactly one of them is 1. Before the first done all three are 0.
- start while busy=1 is ignored and the operands in flight are unchanged. Changes on A/B/signed_mode after capture have no effect.
- done is combined with busy=0, so the block is idle in the done cycle. start=1 in the done cycle is accepted, which gives back-to-back compares with no gap.

## Timing
- Take the start-acceptance edge as edge 0, so busy=1 from edge 0. The result is produced at edge k, where k is the number of digits examined, 1 ≤ k ≤ NDIG.
- After edge k, done=1 for exactly one cycle, Eq/Gt/Sm are valid, and busy=0.
- Best-case latency is 1 cycle (MSB digits differ). Worst case is NDIG cycles (equal operands, or a difference only in digit 0).
- With DIGIT=WIDTH the compare is single-cycle: start at edge 0 gives the result at edge 1.
- Throughput is one compare per k+0 idle cycles: the next start can be accepted in the done cycle itself.
- Critical path is one DIGIT-bit compare plus the state/idx update, independent of WIDTH.

## Test plan
- WIDTH=16, DIGIT=4, unsigned, A=0x1234, B=0x1234, start pulse → busy high for 4 cycles, done after edge 4, Eq=1, Gt=0, Sm=0.
- A=0x8000, B=0x7FFF: unsigned → Gt=1 after edge 1; signed → Sm=1 after edge 1.
- A=0x12A4, B=0x1294, unsigned → Gt=1 after edge 3. Then raise start again in the done cycle with A=0x0001, B=0x0002 → accepted, Sm=1 after 4 more edges.
- Signed, A=0xFFFF (−1), B=0xFFFE (−2) → Gt=1 after edge 4. While busy, drive start=1 with A=0, B=0xFFFF → ignored, and the result is still Gt.
- Start A=0x1234, B=0x1234, assert rst_n=0 at edge 2 → busy=0, done never pulses, Eq/Gt/Sm=0. After release, a fresh compare completes normally.
- WIDTH=8, DIGIT=8, signed, A=0x7F, B=0x80 → Gt=1 after edge 1. Then A=0x80, B=0x80 → Eq=1 after edge 1.
